// File: rtl/peripheral_sync_pkg.sv
// Shared defaults, legal parameter ranges and sizing helper for the
// peripheral synchroniser/filter block.
package peripheral_sync_pkg;

  localparam int unsigned DEF_STAGES     = 2;
  localparam int unsigned DEF_FILTER_CNT = 1;

  localparam int unsigned STAGES_MIN     = 2;
  localparam int unsigned STAGES_MAX     = 4;
  localparam int unsigned FILTER_CNT_MIN = 1;
  localparam int unsigned FILTER_CNT_MAX = 255;

  // Counter width able to hold 0..FILTER_CNT.
  function automatic int unsigned filt_cnt_width(input int unsigned filter_cnt);
    return $clog2(filter_cnt + 1);
  endfunction

endpackage

// File: rtl/peripheral_sync_filter_ch_bb.sv
// One channel: synchroniser chain, stability counter, filtered level and
// registered rise/fall pulses.
module peripheral_sync_filter_ch_bb
  import peripheral_sync_pkg::*;
#(
  parameter int unsigned STAGES     = DEF_STAGES,
  parameter int unsigned FILTER_CNT = DEF_FILTER_CNT,
  parameter logic        RESET_BIT  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic data_i,
  input  logic en_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_c
);

  localparam int unsigned CW = filt_cnt_width(FILTER_CNT);

  logic [STAGES-1:0] sync_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              sync_s;

  assign sync_s = sync_q[STAGES-1];

  // Counter only advances while the synchronised input disagrees with the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (en_i && (sync_s != level_q)) begin
      if (cnt_q == CW'(FILTER_CNT - 1)) begin
        level_d = sync_s;
        rise_d  = sync_s;
        fall_d  = ~sync_s;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= {STAGES{RESET_BIT}};
      cnt_q   <= '0;
      level_q <= RESET_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], data_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign edge_c  = rise_d | fall_d;

endmodule

// File: rtl/peripheral_sync_filter_bb.sv
// Multi-channel input synchroniser with glitch filter and edge reporting;
// per-channel logic lives in peripheral_sync_filter_ch_bb.
module peripheral_sync_filter_bb
  import peripheral_sync_pkg::*;
#(
  parameter int unsigned      WIDTH      = 1,
  parameter int unsigned      STAGES     = DEF_STAGES,
  parameter int unsigned      FILTER_CNT = DEF_FILTER_CNT,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] en,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);

  if ((STAGES < STAGES_MIN) || (STAGES > STAGES_MAX)) begin : g_bad_stages
    $error("peripheral_sync_filter_bb: STAGES out of range 2..4");
  end
  if ((FILTER_CNT < FILTER_CNT_MIN) || (FILTER_CNT > FILTER_CNT_MAX)) begin : g_bad_filter
    $error("peripheral_sync_filter_bb: FILTER_CNT out of range 1..255");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("peripheral_sync_filter_bb: WIDTH must be at least 1");
  end

  logic [WIDTH-1:0] edge_c;
  logic             any_edge_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    peripheral_sync_filter_ch_bb #(
      .STAGES     (STAGES),
      .FILTER_CNT (FILTER_CNT),
      .RESET_BIT  (RESET_VAL[g])
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (data_in[g]),
      .en_i    (en[g]),
      .level_o (data_out[g]),
      .rise_o  (rise[g]),
      .fall_o  (fall[g]),
      .edge_c  (edge_c[g])
    );
  end

  // Registered from the channels' next-state pulses so it lines up with rise/fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= |edge_c;
    end
  end

  assign any_edge = any_edge_q;

endmodule

// File: tb/tb_peripheral_sync_filter_bb.sv
// Bench for peripheral_sync_filter_bb: directed scenarios plus random
// traffic, all compared cycle by cycle against a delay-line/run-length model.
module tb_peripheral_sync_filter_bb;

  localparam int unsigned W  = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned FC = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] data_in;
  logic [W-1:0] en;
  logic [W-1:0] data_out;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         any_edge;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [W-1:0] m_hist [S];
  int           m_run  [W];
  logic [W-1:0] m_dout, m_rise, m_fall;
  logic         m_any;

  peripheral_sync_filter_bb #(
    .WIDTH      (W),
    .STAGES     (S),
    .FILTER_CNT (FC),
    .RESET_VAL  (4'h0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .en       (en),
    .data_out (data_out),
    .rise     (rise),
    .fall     (fall),
    .any_edge (any_edge)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Output follows the input seen S edges ago once it has disagreed for FC enabled edges in a row.
  task automatic model_step();
    logic [W-1:0] seen;
    if (!rst_n) begin
      for (int i = 0; i < int'(S); i++) m_hist[i] = '0;
      for (int i = 0; i < int'(W); i++) m_run[i] = 0;
      m_dout = '0;
      m_rise = '0;
      m_fall = '0;
      m_any  = 1'b0;
    end else begin
      seen   = m_hist[S-1];
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < int'(W); i++) begin
        if (en[i] && (seen[i] != m_dout[i])) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == int'(FC)) begin
            m_dout[i] = seen[i];
            if (seen[i]) m_rise[i] = 1'b1;
            else         m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_any = (m_rise != '0) || (m_fall != '0);
      for (int i = int'(S) - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = data_in;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("data_out", 32'(data_out), 32'(m_dout));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("any_edge", 32'(any_edge), 32'(m_any));
    check("rise_and_fall", 32'(rise & fall), 32'h0);
  endtask

  int n_r, n_f;

  initial begin
    rst_n   = 1'b0;
    data_in = 4'hF;
    en      = 4'hF;
    m_dout  = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;

    // Reset with inputs high, then release
    tick();
    tick();
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_rise", 32'(rise), 32'h0);
    check("rst_any", 32'(any_edge), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 5) check("rel_hold", 32'(data_out), 32'h0);
    end
    check("rel_data_out", 32'(data_out), 32'hF);
    check("rel_rise", 32'(rise), 32'hF);
    tick();
    check("rel_rise_end", 32'(rise), 32'h0);

    data_in = 4'h0;
    repeat (8) tick();

    // Latency on channel 0
    data_in = 4'h1;
    tick();
    repeat (3) begin
      tick();
      check("lat_hold", 32'(data_out[0]), 32'h0);
    end
    tick();
    check("lat_out", 32'(data_out[0]), 32'h1);
    check("lat_rise", 32'(rise[0]), 32'h1);
    tick();
    check("lat_rise_end", 32'(rise[0]), 32'h0);

    // Glitch on channel 1: 2-cycle pulse is filtered, 3-cycle passes
    for (int len = 2; len <= 3; len++) begin
      n_r = 0; n_f = 0;
      data_in[1] = 1'b1;
      repeat (len) begin
        tick();
        n_r += int'(rise[1]); n_f += int'(fall[1]);
      end
      data_in[1] = 1'b0;
      repeat (12) begin
        tick();
        n_r += int'(rise[1]); n_f += int'(fall[1]);
      end
      check("glitch_rise_cnt", 32'(n_r), (len == 2) ? 32'h0 : 32'h1);
      check("glitch_fall_cnt", 32'(n_f), (len == 2) ? 32'h0 : 32'h1);
      check("glitch_level", 32'(data_out[1]), 32'h0);
    end

    // Enable gating on channel 2
    en = 4'hB;
    data_in[2] = 1'b1;
    n_r = 0;
    repeat (10) begin
      tick();
      n_r += int'(rise[2]) + int'(fall[2]);
    end
    check("en_no_pulse", 32'(n_r), 32'h0);
    check("en_level", 32'(data_out[2]), 32'h0);
    en = 4'hF;
    tick(); check("en_wait1", 32'(rise[2]), 32'h0);
    tick(); check("en_wait2", 32'(rise[2]), 32'h0);
    tick(); check("en_rise", 32'(rise[2]), 32'h1);

    // Simultaneous channel events
    data_in = 4'h0;
    repeat (8) tick();
    data_in = 4'h5;
    repeat (4) tick();
    tick();
    check("sim_rise5", 32'(rise), 32'h5);
    check("sim_any", 32'(any_edge), 32'h1);
    tick();
    check("sim_rise_end", 32'(rise), 32'h0);
    check("sim_any_end", 32'(any_edge), 32'h0);
    data_in = 4'hA;
    repeat (4) tick();
    tick();
    check("sim_riseA", 32'(rise), 32'hA);
    check("sim_fall5", 32'(fall), 32'h5);
    check("sim_any2", 32'(any_edge), 32'h1);

    // Reset in the middle of a pending count on channel 3
    data_in = 4'h0;
    repeat (8) tick();
    data_in = 4'h8;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_rise", 32'(rise[3]), 32'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k < 5) begin
        check("mid_hold", 32'(data_out), 32'h0);
        check("mid_no_rise", 32'(rise[3]), 32'h0);
      end
    end
    check("mid_out", 32'(data_out), 32'h8);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      if (($urandom % 4) == 0) data_in = data_in ^ W'($urandom);
      if (($urandom % 8) == 0) en = W'($urandom);
      rst_n = (($urandom % 64) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
